// File: rtl/lsu_split.sv
// Load/store unit: registered core handshake to a request/grant data bus, with lane steering and load extension.
// Define LSU_MISALIGNED_EN to allow misaligned accesses (bus-crossing ones are split into two beats).
module lsu_split #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_i,
    output logic                    ready_o,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [1:0]              type_i,
    input  logic                    sign_ext_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    bus_req_o,
    input  logic                    bus_gnt_i,
    output logic [ADDR_WIDTH-1:0]   bus_addr_o,
    output logic                    bus_we_o,
    output logic [DATA_WIDTH/8-1:0] bus_be_o,
    output logic [DATA_WIDTH-1:0]   bus_wdata_o,
    input  logic                    bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   bus_rdata_i
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BEW   = 2 * BYTES;
    localparam int OFFW  = $clog2(BYTES);
    localparam int SHW   = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [1:0]              type_q, type_d;
    logic                    sext_q, sext_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    in_illegal;
    logic [OFFW-1:0]         off;
    logic [SHW-1:0]          shamt;
    logic [BEW-1:0]          be_ones;
    logic [BYTES-1:0]        be1;
    logic [DATA_WIDTH-1:0]   wrot;
    logic [DATA_WIDTH-1:0]   base_addr;
    logic [DATA_WIDTH-1:0]   merged, rot, ext_mask, load_res;
    logic                    sbit;
`ifdef LSU_MISALIGNED_EN
    logic [BEW-1:0]          be_full;
    logic [BYTES-1:0]        be2;
    logic                    crossing;
    logic [DATA_WIDTH-1:0]   merge_q, merge_d;
`endif

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [BYTES-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < BYTES; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    always_comb begin
        in_illegal = (DATA_WIDTH == 32) && (type_i == 2'b11);
`ifndef LSU_MISALIGNED_EN
        in_illegal = in_illegal || ((addr_i[3:0] & ((4'd1 << type_i) - 4'd1)) != 4'd0);
`endif
    end

    always_comb begin
        off     = addr_q[OFFW-1:0];
        shamt   = {off, 3'b000};
        be_ones = (BEW'(1) << (4'd1 << type_q)) - BEW'(1);
`ifdef LSU_MISALIGNED_EN
        be_full  = be_ones << off;
        be1      = be_full[BYTES-1:0];
        be2      = be_full[BEW-1:BYTES];
        crossing = |be2;
`else
        be1      = BYTES'(be_ones << off);
`endif
        wrot      = (wdata_q << shamt) | (wdata_q >> (DATA_WIDTH - int'(shamt)));
        base_addr = '0;
        base_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    end

    // Beat-2 lanes are OR-ed onto the beat-1 lanes held in merge_q.
    always_comb begin
        merged = bus_rdata_i & lane_mask(be1);
`ifdef LSU_MISALIGNED_EN
        if (state_q == WAIT2) merged = merge_q | (bus_rdata_i & lane_mask(be2));
`endif
        rot = (merged >> shamt) | (merged << (DATA_WIDTH - int'(shamt)));
        case (type_q)
            2'b00:   begin ext_mask = DATA_WIDTH'(8'hFF);         sbit = rot[7];  end
            2'b01:   begin ext_mask = DATA_WIDTH'(16'hFFFF);      sbit = rot[15]; end
            2'b10:   begin ext_mask = DATA_WIDTH'(32'hFFFF_FFFF); sbit = rot[31]; end
            default: begin ext_mask = '1;                         sbit = rot[DATA_WIDTH-1]; end
        endcase
        load_res = (rot & ext_mask) | (~ext_mask & {DATA_WIDTH{sext_q & sbit}});
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        type_d   = type_q;
        sext_d   = sext_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    type_d  = type_i;
                    sext_d  = sign_ext_i;
                    wdata_d = wdata_i;
                    if (in_illegal) begin
                        state_d  = DONE;
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d = ISSUE1;
                    end
                end
            end
            ISSUE1: if (bus_gnt_i) state_d = WAIT1;
            WAIT1: begin
                if (bus_rvalid_i) begin
`ifdef LSU_MISALIGNED_EN
                    if (crossing) begin
                        state_d = ISSUE2;
                    end else begin
                        state_d  = DONE;
                        rvalid_d = 1'b1;
                        rdata_d  = we_q ? '0 : load_res;
                    end
`else
                    state_d  = DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? '0 : load_res;
`endif
                end
            end
`ifdef LSU_MISALIGNED_EN
            ISSUE2: if (bus_gnt_i) state_d = WAIT2;
            WAIT2: begin
                if (bus_rvalid_i) begin
                    state_d  = DONE;
                    rvalid_d = 1'b1;
                    rdata_d  = we_q ? '0 : load_res;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_addr_o  = '0;
        bus_we_o    = 1'b0;
        bus_be_o    = '0;
        bus_wdata_o = '0;
        if (state_q == ISSUE1) begin
            bus_req_o   = 1'b1;
            bus_addr_o  = ADDR_WIDTH'(base_addr);
            bus_we_o    = we_q;
            bus_be_o    = be1;
            bus_wdata_o = wrot;
        end
`ifdef LSU_MISALIGNED_EN
        if (state_q == ISSUE2) begin
            bus_req_o   = 1'b1;
            bus_addr_o  = ADDR_WIDTH'(base_addr) + ADDR_WIDTH'(BYTES);
            bus_we_o    = we_q;
            bus_be_o    = be2;
            bus_wdata_o = wrot;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            type_q   <= '0;
            sext_q   <= 1'b0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            type_q   <= type_d;
            sext_q   <= sext_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

`ifdef LSU_MISALIGNED_EN
    always_comb merge_d = (state_q == WAIT1 && bus_rvalid_i) ? merged : merge_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) merge_q <= '0;
        else     merge_q <= merge_d;
    end
`endif

    assign ready_o  = (state_q == IDLE);
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_lsu_split.sv
// Scoreboard bench for lsu_split at DATA_WIDTH=32: expected bus beats and completions are queued
// when a request is driven and compared when the bus model sees a request or the DUT completes.
module tb_lsu_split;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_i, ready_o, we_i, sign_ext_i;
    logic [AW-1:0] addr_i;
    logic [1:0]    type_i;
    logic [DW-1:0] wdata_i;
    logic          rvalid_o, err_o;
    logic [DW-1:0] rdata_o;
    logic          bus_req_o, bus_gnt_i, bus_we_o, bus_rvalid_i;
    logic [AW-1:0] bus_addr_o;
    logic [3:0]    bus_be_o;
    logic [DW-1:0] bus_wdata_o, bus_rdata_i;

    always #5 clk = ~clk;

    lsu_split #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .ready_o(ready_o), .we_i(we_i),
        .addr_i(addr_i), .type_i(type_i), .sign_ext_i(sign_ext_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rsp;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    beat_t beat_q[$];
    exp_t  exp_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, txn_start = 0, done_cnt = 0, gnt_cnt = 0, req_hi_cnt = 0;
    int gnt_stall = 0, rsp_delay = 0;
    int stall = 0, wait_n = 0;
    bit pend = 0;
    logic [31:0] pdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus responder: checks each requested beat against the queue, stalls grant, returns data.
    initial begin
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        forever begin
            @(negedge clk);
            bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
            if (rst) begin
                stall = 0; pend = 0;
            end else if (pend) begin
                if (wait_n == 0) begin
                    bus_rvalid_i = 1'b1; bus_rdata_i = pdata; pend = 0;
                end else begin
                    wait_n--;
                end
            end else if (bus_req_o) begin
                req_hi_cnt++;
                if (beat_q.size() == 0) begin
                    check("unexpected_bus_req", 1, 0);
                end else begin
                    check("bus_addr", bus_addr_o, beat_q[0].addr);
                    check("bus_be", bus_be_o, beat_q[0].be);
                    check("bus_we", bus_we_o, beat_q[0].we);
                    check("bus_wdata", bus_wdata_o, beat_q[0].wdata);
                    if (stall < gnt_stall) begin
                        stall++;
                    end else begin
                        bus_gnt_i = 1'b1;
                        pdata = beat_q[0].rsp;
                        void'(beat_q.pop_front());
                        pend = 1; wait_n = rsp_delay; stall = 0;
                        gnt_cnt++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && rvalid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rdata", rdata_o, e.rdata);
                check("err", err_o, e.err);
                check("latency", cyc - txn_start, e.lat);
            end
            done_cnt++;
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [3:0] be, input logic we,
                             input logic [31:0] wd, input logic [31:0] rsp);
        beat_q.push_back('{a, be, we, wd, rsp});
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] typ,
                       input logic sext, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
        int d0;
        bit ok;
        exp_q.push_back('{exp_rdata, exp_err, lat});
        @(posedge clk); #1;
        req_i = 1'b1; we_i = we; addr_i = addr; type_i = typ; sign_ext_i = sext; wdata_i = wdata;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ready_o) ok = 1;
        end
        if (!ok) begin
            check("ready_timeout", 0, 1);
            req_i = 1'b0; exp_q.delete(); beat_q.delete();
            return;
        end
        txn_start = cyc;
        d0 = done_cnt;
        @(posedge clk); #1;
        req_i = 1'b0; we_i = 1'($urandom); addr_i = $urandom; type_i = 2'($urandom);
        sign_ext_i = 1'($urandom); wdata_i = $urandom;
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk); #1;
            if (done_cnt != d0) ok = 1;
        end
        if (!ok) begin
            check("done_timeout", 0, 1);
            exp_q.delete(); beat_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        check({pfx, "_ready"}, ready_o, 1);
        check({pfx, "_bus_req"}, bus_req_o, 0);
        check({pfx, "_rvalid"}, rvalid_o, 0);
        check({pfx, "_rdata"}, rdata_o, 0);
        check({pfx, "_err"}, err_o, 0);
        check({pfx, "_bus_addr"}, bus_addr_o, 0);
        check({pfx, "_bus_be"}, bus_be_o, 0);
        check({pfx, "_bus_we"}, bus_we_o, 0);
        check({pfx, "_bus_wdata"}, bus_wdata_o, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g0, d0, r0;
        bit ok;
        rst = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; type_i = '0;
        sign_ext_i = 1'b0; wdata_i = '0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #2 rst = 1'b0;

        push_beat(32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
        txn(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h8A000000);
        txn(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 32'hFFFFFF8A, 1'b0, 3);
        push_beat(32'h100, 4'b1000, 1'b0, 32'h0, 32'h8A000000);
        txn(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 32'h0000008A, 1'b0, 3);
        push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'hBEEF1234);
        txn(1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 32'h0000BEEF, 1'b0, 3);
        push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'hBEEF1234);
        txn(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
        push_beat(32'h104, 4'b1111, 1'b1, 32'h12345678, 32'hFFFFFFFF);
        txn(1'b1, 32'h104, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 3);
        push_beat(32'h100, 4'b0010, 1'b1, 32'h0000AB00, 32'hFFFFFFFF);
        txn(1'b1, 32'h101, 2'b00, 1'b0, 32'h000000AB, 32'h0, 1'b0, 3);
        txn(1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 1);

`ifdef LSU_MISALIGNED_EN
        push_beat(32'h100, 4'b1100, 1'b0, 32'h0, 32'h33440000);
        push_beat(32'h104, 4'b0011, 1'b0, 32'h0, 32'h00001122);
        txn(1'b0, 32'h102, 2'b10, 1'b0, 32'h0, 32'h11223344, 1'b0, 5);
        push_beat(32'h100, 4'b1000, 1'b1, 32'hCD0000AB, 32'hFFFFFFFF);
        push_beat(32'h104, 4'b0001, 1'b1, 32'hCD0000AB, 32'hFFFFFFFF);
        txn(1'b1, 32'h103, 2'b01, 1'b0, 32'h0000ABCD, 32'h0, 1'b0, 5);
        push_beat(32'h100, 4'b0110, 1'b0, 32'h0, 32'h00BEEF00);
        txn(1'b0, 32'h101, 2'b01, 1'b1, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
`else
        txn(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        txn(1'b1, 32'h103, 2'b01, 1'b0, 32'h0000ABCD, 32'h0, 1'b1, 1);
`endif

        gnt_stall = 2; rsp_delay = 1;
        push_beat(32'h108, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D);
        txn(1'b0, 32'h108, 2'b10, 1'b0, 32'h0, 32'h0BADF00D, 1'b0, 6);

        // Reset abandoning a load stuck in WAIT1.
        gnt_stall = 3; rsp_delay = 5;
        push_beat(32'h10C, 4'b1111, 1'b0, 32'h0, 32'h55AA55AA);
        @(posedge clk); #1;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10C; type_i = 2'b10; sign_ext_i = 1'b0; wdata_i = '0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ready_o) ok = 1;
        end
        if (!ok) check("rst_ready_timeout", 0, 1);
        g0 = gnt_cnt; r0 = req_hi_cnt;
        @(posedge clk); #1 req_i = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            if (gnt_cnt != g0) ok = 1;
        end
        if (!ok) check("rst_grant_timeout", 0, 1);
        check("req_held_cycles", req_hi_cnt - r0, 4);
        #2 rst = 1'b1;
        #1 check_idle_outputs("midrst");
        exp_q.delete(); beat_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        check("no_rvalid_after_reset", done_cnt - d0, 0);

        gnt_stall = 0; rsp_delay = 0;
        push_beat(32'h200, 4'b0011, 1'b0, 32'h0, 32'h00007F01);
        txn(1'b0, 32'h200, 2'b01, 1'b1, 32'h0, 32'h00007F01, 1'b0, 3);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_split.md
# lsu_split

Parametrised load/store unit between the core's execute stage and a request/grant data bus. It replaces the tightly coupled, single-cycle data path with a registered handshake on both sides. It supports byte/halfword/word (and doubleword at 64-bit width) accesses, correct sign/zero extension at any byte offset, and splitting of misaligned accesses into two bus beats. Only one transaction is outstanding at a time.

## Interface
Parameters:
- DATA_WIDTH, 32: bus and register data width; legal values are 32 and 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_i  in  1  core request; held stable until accepted.
- ready_o  out  1  request accepted when req_i & ready_o.
- we_i  in  1  0 = load, 1 = store.
- addr_i  in  ADDR_WIDTH  byte address.
- type_i  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (only legal at DATA_WIDTH=64).
- sign_ext_i  in  1  sign-extend the load result.
- wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
- rvalid_o  out  1  one-cycle completion pulse, for loads and stores.
- rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- err_o  out  1  qualifies rvalid_o: the access was illegal and was not performed.
- bus_req_o  out  1  bus request.
- bus_gnt_i  in  1  bus grant.
- bus_addr_o  out  ADDR_WIDTH  beat address, aligned to BYTES.
- bus_we_o  out  1  beat direction.
- bus_be_o  out  BYTES  byte-lane enables.
- bus_wdata_o  out  DATA_WIDTH  lane-aligned store data.
- bus_rvalid_i  in  1  beat response; arrives at least 1 cycle after grant.
- bus_rdata_i  in  DATA_WIDTH  read data, valid with bus_rvalid_i.

## Operation
- SIZE = 1 << type_i. OFF = addr_i mod BYTES.
- Misaligned means addr_i mod SIZE != 0. Crossing means OFF + SIZE > BYTES.
- On accept, all request fields are latched. Core inputs are ignored until the next acceptance.
- FSM states: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
  - IDLE: ready_o = 1. On accept, go to ISSUE1. If the access is illegal, go to DONE with err.
  - ISSUE1: assert bus_req_o. On bus_gnt_i, go to WAIT1.
  - WAIT1: on bus_rvalid_i, go to ISSUE2 if crossing, else DONE.
  - ISSUE2: assert bus_req_o. On bus_gnt_i, go to WAIT2.
  - WAIT2: on bus_rvalid_i, go to DONE.
  - DONE: pulse rvalid_o, then go to IDLE.
- Beat 1:
  - bus_addr_o = addr aligned down to BYTES.
  - bus_be_o = low BYTES bits of (SIZE-ones << OFF).
- Beat 2:
  - bus_addr_o = beat-1 address + BYTES.
  - bus_be_o = the bits of the same mask that overflow past BYTES.
- bus_wdata_o = wdata rotated left by 8*OFF, on both beats.
- Load assembly:
  - Merge beat-1 lanes selected by its BE with beat-2 lanes selected by its BE.
  - Rotate the merge right by 8*OFF.
  - Extend from bit 8*SIZE-1: sign-extend when sign_ext_i, else zero-extend.
- Illegal accesses: type 11 at DATA_WIDTH=32, or misaligned without LSU_MISALIGNED_EN (see Configuration). These produce no bus activity and complete with err_o = 1 and rdata_o = 0.
- While bus_req_o is high, bus_addr_o, bus_we_o, bus_be_o and bus_wdata_o are stable until grant.
- bus_rvalid_i outside WAIT1/WAIT2 is ignored.

## Timing
- Reset values: state IDLE; ready_o 1; all other outputs 0. Latched fields are 0.
- Reset asserted mid-transaction abandons it. bus_req_o drops asynchronously, and no rvalid_o is produced for it.
- Latency, with grant in the same cycle and rvalid 1 cycle after grant:
  - Cycle 0: accept.
  - Cycle 1: bus_req_o and grant.
  - Cycle 2: bus_rvalid_i.
  - Cycle 3: rvalid_o.
  - A split access adds 2 cycles. An error completes at cycle 1.
- Throughput: the next request can be accepted in the cycle after rvalid_o.
- Each grant stall cycle adds exactly 1 cycle. Each response wait cycle adds exactly 1 cycle.
- rvalid_o, rdata_o and err_o are registered outputs. ready_o is decoded from state.

## Configuration
- LSU_MISALIGNED_EN defined: misaligned accesses are legal. Crossing accesses are split into 2 beats. Non-crossing misaligned accesses use 1 beat with shifted BE.
- LSU_MISALIGNED_EN undefined: any misaligned access is an error. ISSUE2 and WAIT2 are not synthesised.

## Test plan
All scenarios use DATA_WIDTH=32.
- Aligned LW at 0x100, bus_rdata 0xDEADBEEF, immediate grant:
  - Required: bus_addr 0x100, be 1111, rvalid_o at cycle 3, rdata_o 0xDEADBEEF, err_o 0.
- LB at 0x103, bus_rdata 0x8A000000:
  - Required: be 1000; rdata_o 0xFFFFFF8A when signed, 0x0000008A when unsigned.
- Macro on, LW at 0x102; beat-1 rdata 0x33440000, beat-2 rdata 0x00001122:
  - Required: beat 1 at 0x100 with be 1100, beat 2 at 0x104 with be 0011, rdata_o 0x11223344, rvalid_o at cycle 5.
- Macro on, SH at 0x103, wdata 0x0000ABCD:
  - Required: beat 1 at 0x100 with be 1000 and wdata 0xCD0000AB; beat 2 at 0x104 with be 0001 and the same wdata; rvalid_o with rdata_o 0.
- Macro off, LW at 0x101:
  - Required: bus_req_o never asserted; rvalid_o and err_o at cycle 1; rdata_o 0.
- Grant held low 3 cycles, then rst pulsed during WAIT1:
  - Required: bus_req_o and all bus fields stable for 4 cycles. On reset, all outputs 0 and ready_o 1; no rvalid_o after release.
